// File: rtl/uart_rx_oversample.sv
// -----------------------------------------------------------------------------
// uart_rx_oversample
//   UART receive front end. A baud-enable generator drives an 8x-oversampling
//   receiver for 8N1 frames, or 8E1/8O1 frames when PARITY is set. Each good
//   byte appears on rx_data together with a one-clk rx_rdy strobe. The 1x and
//   8x baud enables are exported so a local transmitter or stimulus can use
//   the same timing.
//
//   Parameters
//     BD8_DIV  clk cycles per 8x tick (>= 2)
//     PARITY   "NONE" | "EVEN" | "ODD"
//
//   Ports
//     clk        in   system clock, rising edge
//     rst        in   asynchronous active-high reset
//     rx         in   serial line, asynchronous to clk, idles high
//     rx_data    out  [7:0] last correctly received byte
//     rx_rdy     out  one-clk pulse when rx_data has just been updated
//     rx_bd_en   out  one-clk pulse at the 8x baud rate
//     tx_bd_en   out  one-clk pulse at the 1x baud rate
//     frame_err  out  (UART_RX_ERR_EN only) one-clk pulse: stop bit sampled 0
//     parity_err out  (UART_RX_ERR_EN only) one-clk pulse: parity check failed
//
//   Optional feature: define UART_RX_ERR_EN to add frame_err and parity_err.
// -----------------------------------------------------------------------------
module uart_rx_oversample #(
    parameter int    BD8_DIV = 54,
    parameter string PARITY  = "NONE"
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       rx_bd_en,
    output logic       tx_bd_en
`ifdef UART_RX_ERR_EN
    ,
    output logic       frame_err,
    output logic       parity_err
`endif
);

    localparam int DW = (BD8_DIV > 2) ? $clog2(BD8_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(BD8_DIV - 1);
    localparam bit PAR_EN  = (PARITY != "NONE");
    localparam bit PAR_ODD = (PARITY == "ODD");

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    // ---------------- baud generator ----------------
    logic [DW-1:0] div_cnt;
    logic [2:0]    tick_cnt;
    logic          div_last;

    assign div_last = (div_cnt == DIV_LAST);

    // The tick counter advances at the same edge that sets rx_bd_en. This
    // makes tx_bd_en coincide with the rx_bd_en pulse on which the tick
    // count wraps from 7 to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
            rx_bd_en <= 1'b0;
            tx_bd_en <= 1'b0;
        end else begin
            rx_bd_en <= div_last;
            tx_bd_en <= div_last && (tick_cnt == 3'd7);
            if (div_last) begin
                div_cnt  <= '0;
                tick_cnt <= tick_cnt + 3'd1;
            end else begin
                div_cnt  <= div_cnt + DW'(1);
            end
        end
    end

    // ---------------- input synchronizer ----------------
    // The synchronizer flops reset to 0. A line that is already low when
    // reset is released therefore shows no 1->0 edge and cannot start a frame.
    logic rx_s1, rx_s2, rx_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1   <= 1'b0;
            rx_s2   <= 1'b0;
            rx_prev <= 1'b0;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            if (rx_bd_en)
                rx_prev <= rx_s2;
        end
    end

    // ---------------- receiver FSM ----------------
    state_t     state, state_n;
    logic [2:0] cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic [7:0] shreg, shreg_n;
    logic       par_ok, par_ok_n;
    logic [7:0] data_n;
    logic       rdy_n;
`ifdef UART_RX_ERR_EN
    logic       ferr_n, perr_n;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            par_ok  <= 1'b1;
            rx_data <= '0;
            rx_rdy  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            shreg   <= shreg_n;
            par_ok  <= par_ok_n;
            rx_data <= data_n;
            rx_rdy  <= rdy_n;
        end
    end

`ifdef UART_RX_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            frame_err  <= ferr_n;
            parity_err <= perr_n;
        end
    end
`endif

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        shreg_n  = shreg;
        par_ok_n = par_ok;
        data_n   = rx_data;
        rdy_n    = 1'b0;
`ifdef UART_RX_ERR_EN
        ferr_n   = 1'b0;
        perr_n   = 1'b0;
`endif
        if (rx_bd_en) begin
            case (state)
                IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        state_n = START;
                        cnt_n   = '0;
                    end
                end
                START: begin
                    // Recheck the line at mid start bit. A line that is high
                    // again here was only a glitch.
                    if (cnt == 3'd3) begin
                        cnt_n = '0;
                        if (rx_s2) begin
                            state_n = IDLE;
                        end else begin
                            state_n = DATA;
                            idx_n   = '0;
                        end
                    end else begin
                        cnt_n = cnt + 3'd1;
                    end
                end
                DATA: begin
                    cnt_n = cnt + 3'd1;            // wraps 7 -> 0 at each bit centre
                    if (cnt == 3'd7) begin
                        shreg_n[idx] = rx_s2;
                        if (idx == 3'd7) begin
                            state_n  = PAR_EN ? PAR : STOP;
                            par_ok_n = 1'b1;
                        end else begin
                            idx_n = idx + 3'd1;
                        end
                    end
                end
                PAR: begin
                    cnt_n = cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        par_ok_n = ((^shreg) ^ rx_s2) == PAR_ODD;
                        state_n  = STOP;
                    end
                end
                STOP: begin
                    cnt_n = cnt + 3'd1;
                    // Leave at the stop-bit centre. This leaves half a bit to
                    // catch a start bit that follows with no idle gap.
                    if (cnt == 3'd7) begin
                        state_n = IDLE;
                        if (rx_s2 && par_ok) begin
                            data_n = shreg;
                            rdy_n  = 1'b1;
                        end
`ifdef UART_RX_ERR_EN
                        ferr_n = !rx_s2;
                        perr_n = !par_ok;
`endif
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_oversample
//   Scoreboard bench for uart_rx_oversample. Two instances share clk and rst:
//   dut (no parity) and dut_p (even parity). Each instance has its own serial
//   line. Stimulus tasks push the bytes they expect into a queue. A monitor
//   pops one entry and compares it on every rx_rdy strobe.
// -----------------------------------------------------------------------------
module tb_uart_rx_oversample;

    localparam int DIV = 54;
    localparam int BIT = 8 * DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx, rx_p;
    logic [7:0] rx_data, rx_data_p;
    logic       rx_rdy, rx_rdy_p;
    logic       rx_bd_en, rx_bd_en_p;
    logic       tx_bd_en, tx_bd_en_p;
`ifdef UART_RX_ERR_EN
    logic       frame_err, parity_err, frame_err_p, parity_err_p;
    int         ferr_cnt = 0, perr_cnt = 0, pferr_cnt = 0, pperr_cnt = 0;
`endif

    uart_rx_oversample #(.BD8_DIV(DIV), .PARITY("NONE")) dut (
        .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_rdy(rx_rdy),
        .rx_bd_en(rx_bd_en), .tx_bd_en(tx_bd_en)
`ifdef UART_RX_ERR_EN
        , .frame_err(frame_err), .parity_err(parity_err)
`endif
    );

    uart_rx_oversample #(.BD8_DIV(DIV), .PARITY("EVEN")) dut_p (
        .clk(clk), .rst(rst), .rx(rx_p), .rx_data(rx_data_p), .rx_rdy(rx_rdy_p),
        .rx_bd_en(rx_bd_en_p), .tx_bd_en(tx_bd_en_p)
`ifdef UART_RX_ERR_EN
        , .frame_err(frame_err_p), .parity_err(parity_err_p)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_pq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest expected byte.
    always @(negedge clk) begin
        if (rx_rdy === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL rx_rdy_unexpected: strobe with data %0h, expected none", rx_data);
            end else
                check("rx_data", rx_data, exp_q.pop_front());
        end
        if (rx_rdy_p === 1'b1) begin
            if (exp_pq.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL rx_rdy_p_unexpected: strobe with data %0h, expected none", rx_data_p);
            end else
                check("rx_data_p", rx_data_p, exp_pq.pop_front());
        end
`ifdef UART_RX_ERR_EN
        if (frame_err === 1'b1)    ferr_cnt++;
        if (parity_err === 1'b1)   perr_cnt++;
        if (frame_err_p === 1'b1)  pferr_cnt++;
        if (parity_err_p === 1'b1) pperr_cnt++;
`endif
    end

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit which, input logic v);
        if (which) rx_p = v;
        else       rx   = v;
    endtask

    task automatic send(input bit which, input logic [7:0] d, input bit has_p,
                        input logic p, input logic stop);
        drive(which, 1'b0); wclk(BIT);
        for (int i = 0; i < 8; i++) begin
            drive(which, d[i]); wclk(BIT);
        end
        if (has_p) begin
            drive(which, p); wclk(BIT);
        end
        drive(which, stop); wclk(BIT);
        drive(which, 1'b1);
    endtask

    // Wait, with a bound, for the next cycle in which the chosen enable is high.
    task automatic wait_sig(input bit sel_tx, output int t, output bit ok);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if ((sel_tx ? tx_bd_en : rx_bd_en) === 1'b1) begin
                t  = cyc;
                ok = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        int t0, t1;
        bit ok0, ok1;
        bit co;

        // Reset with the line held low.
        rst = 1'b1; rx = 1'b0; rx_p = 1'b1;
        wclk(5);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_rdy", rx_rdy, 1'b0);
        check("reset_rx_bd_en", rx_bd_en, 1'b0);
        check("reset_tx_bd_en", tx_bd_en, 1'b0);
`ifdef UART_RX_ERR_EN
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_parity_err", parity_err, 1'b0);
`endif
        rst = 1'b0;
        wclk(3 * BIT);
        rx = 1'b1;
        wclk(10 * BIT);
        check("low_since_reset_rx_data", rx_data, 8'h00);

        // Baud enables.
        wait_sig(1'b0, t0, ok0);
        wait_sig(1'b0, t1, ok1);
        check("rx_bd_en_seen", {31'd0, ok0 & ok1}, 1);
        check("rx_bd_en_period", t1 - t0, DIV);
        wait_sig(1'b1, t0, ok0);
        co = (rx_bd_en === 1'b1);
        wait_sig(1'b1, t1, ok1);
        check("tx_bd_en_seen", {31'd0, ok0 & ok1}, 1);
        check("tx_bd_en_coincident", {31'd0, co}, 1);
        check("tx_bd_en_period", t1 - t0, 8 * DIV);

        // Single frame.
        exp_q.push_back(8'hAD);
        send(1'b0, 8'hAD, 1'b0, 1'b0, 1'b1);
        wclk(2 * BIT);
        check("single_ad_drained", exp_q.size(), 0);

        // Back-to-back frames.
        repeat (3) exp_q.push_back(8'hAD);
        repeat (3) send(1'b0, 8'hAD, 1'b0, 1'b0, 1'b1);
        wclk(2 * BIT);
        check("b2b_drained", exp_q.size(), 0);

        // Low glitch of two ticks, then a clean frame.
        rx = 1'b0; wclk(2 * DIV); rx = 1'b1;
        wclk(2 * BIT);
        check("glitch_rx_data", rx_data, 8'hAD);
        exp_q.push_back(8'h5A);
        send(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
        wclk(2 * BIT);
        check("after_glitch_drained", exp_q.size(), 0);

        // Bad stop bit.
        send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
        wclk(2 * BIT);
        check("bad_stop_rx_data", rx_data, 8'h5A);
`ifdef UART_RX_ERR_EN
        check("bad_stop_frame_err", ferr_cnt, 1);
        check("bad_stop_parity_err", perr_cnt, 0);
`endif

        // Reset in the middle of data bit 4. Bits 4..7 of 0xF0 and the stop
        // bit are all high, so after reset the line shows no new start edge.
        fork
            send(1'b0, 8'hF0, 1'b0, 1'b0, 1'b1);
            begin
                wclk(5 * BIT + BIT / 2);
                rst = 1'b1;
                wclk(3);
                check("midframe_rst_rx_data", rx_data, 8'h00);
                check("midframe_rst_rx_rdy", rx_rdy, 1'b0);
                rst = 1'b0;
            end
        join
        wclk(2 * BIT);
        check("after_rst_rx_data", rx_data, 8'h00);
        exp_q.push_back(8'hC3);
        send(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
        wclk(2 * BIT);
        check("after_rst_drained", exp_q.size(), 0);

        // Even parity: 0xAD has five ones, so p=1 is good and p=0 is bad.
        exp_pq.push_back(8'hAD);
        send(1'b1, 8'hAD, 1'b1, 1'b1, 1'b1);
        wclk(2 * BIT);
        send(1'b1, 8'hAD, 1'b1, 1'b0, 1'b1);
        wclk(2 * BIT);
        check("parity_drained", exp_pq.size(), 0);
        check("parity_bad_rx_data", rx_data_p, 8'hAD);
`ifdef UART_RX_ERR_EN
        check("parity_err_count", pperr_cnt, 1);
        check("parity_frame_err_count", pferr_cnt, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
